// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a carry
// flip-flop. An accepted start loads the operands; one sum bit is produced per
// clock and the WIDTH-bit result plus carry-out are registered on the edge
// that enters DONE.
//
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to add the registered
// signed-overflow output. Without it there is no overflow port or logic.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands, carry-in and counter load on start
// SHIFT | one bit per clock through the full-adder cell; busy is high
// DONE  | result registered; done pulses for this single cycle

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // single full-adder cell: sum bit and majority carry
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic [WIDTH-1:0] ss_next;
  logic             c;
  logic [CW-1:0]    cnt;

  logic load;
  logic finish;
  logic s_bit;
  logic co_bit;

  // the LSB of ss falls off the end of the shift and is never read
  logic unused_ss_lsb;
  assign unused_ss_lsb = ss[0];

  serial_adder_fa u_fa (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (c),
    .s  (s_bit),
    .co (co_bit)
  );

  // new sum bit enters at the MSB; after WIDTH shifts this is the full result
  assign ss_next = {s_bit, ss[WIDTH-1:1]};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and controller outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // operand/sum shift registers, carry flop and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      ss  <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (busy) begin
      sa  <= {1'b0, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      ss  <= ss_next;
      c   <= co_bit;
      cnt <= cnt + CW'(1);
    end
  end

  // result registers: written only on the edge entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (finish) begin
      sum  <= ss_next;
      cout <= co_bit;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  // on the last bit, c is the carry into the MSB; differing from the carry out
  // of the MSB means the two's-complement result overflowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (finish) begin
      overflow <= co_bit ^ c;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 instance for directed, table and random
// checks, and a WIDTH=3 instance for a second random run.

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       s8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       s3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  logic ov8, ov3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .overflow(ov3)
`endif
  );

`ifndef SERIAL_ADDER_OVERFLOW_EN
  assign ov8 = 1'b0;
  assign ov3 = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [32:0] full;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } pend_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // one addition on the 8-bit instance with one-cycle start; checks done timing
  task automatic add8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
    int seen = -1;
    int pulses = 0;
    int both = 0;
    logic [7:0] got_s = '0;
    logic got_c = 1'b0;
    logic got_o = 1'b0;
    @(negedge clk);
    s8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(posedge clk); #1;
    chk({tag, "_busy_on_accept"}, busy8, 1'b1);
    @(negedge clk);
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (busy8 && done8) both++;
      if (done8) begin
        pulses++;
        if (seen < 0) begin
          seen  = i;
          got_s = sum8;
          got_c = cout8;
          got_o = ov8;
        end
      end
    end
    chk({tag, "_done_edge"}, seen, 8);
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_busy_and_done"}, both, 0);
    chk({tag, "_sum"}, got_s, es);
    chk({tag, "_cout"}, got_c, ec);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk({tag, "_ovf"}, got_o, eo);
`endif
  endtask

  // start held high with fresh random operands every cycle; the model predicts
  // which edges accept (every w+2 edges) and when each done/busy must appear
  task automatic run_rand(input int w, input int n);
    pend_t q[$];
    int accepted = 0;
    int cd = 0;
    int i = 0;
    int limit = n * (w + 2) + 50;
    logic [31:0] mask = (32'h1 << w) - 32'h1;
    logic [31:0] ra, rb;
    logic rc, st;
    logic bz, dn, co, ov, exp_done, exp_busy, exp_ov;
    logic [31:0] sm, es;
    while ((accepted < n || q.size() > 0) && i < limit) begin
      @(negedge clk);
      if (w == 8) begin
        bz = busy8; dn = done8; sm = 32'(sum8); co = cout8; ov = ov8;
      end else begin
        bz = busy3; dn = done3; sm = 32'(sum3); co = cout3; ov = ov3;
      end
      exp_done = (q.size() > 0) && (q[0].due == i);
      exp_busy = (q.size() > 0) && (i >= q[0].due - w) && (i < q[0].due);
      chk("rand_done", dn, exp_done);
      chk("rand_busy", bz, exp_busy);
      if (exp_done) begin
        es = q[0].full[31:0] & mask;
        exp_ov = (q[0].a[w-1] == q[0].b[w-1]) && (es[w-1] != q[0].a[w-1]);
        chk("rand_sum", sm, es);
        chk("rand_cout", co, q[0].full[w]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("rand_ovf", ov, exp_ov);
`endif
        void'(q.pop_front());
      end
      st = (accepted < n);
      ra = $urandom & mask;
      rb = $urandom & mask;
      rc = 1'($urandom);
      if (w == 8) begin
        s8 = st; a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc;
      end else begin
        s3 = st; a3 = ra[2:0]; b3 = rb[2:0]; cin3 = rc;
      end
      if (cd == 0 && st) begin
        q.push_back('{full: 33'(ra) + 33'(rb) + 33'(rc), a: ra, b: rb, due: i + w + 1});
        accepted++;
        cd = w + 1;
      end else if (cd > 0) begin
        cd--;
      end
      i++;
    end
    chk("rand_all_accepted", accepted, n);
    chk("rand_drained", q.size(), 0);
    s8 = 1'b0; s3 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [7:0] got_s;
    logic got_c;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};

    // reset release, then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", sum8, 8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    chk("rst_done3", done3, 1'b0);
    chk("rst_sum3", sum3, 3'h0);
    chk("rst_cout3", cout3, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("rst_ovf8", ov8, 1'b0);
`endif

    // table vectors
    for (int v = 0; v < 8; v++) begin
      add8(tbl[v].a, tbl[v].b, tbl[v].ci, tbl[v].s, tbl[v].co, tbl[v].ov, $sformatf("vec%0d", v));
    end

    // reset in the middle of SHIFT discards the addition and clears outputs
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", busy8, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_sum", sum8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("mid_rst_ovf", ov8, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    add8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "after_rst");

    // start during SHIFT is ignored and not queued
    @(negedge clk);
    s8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    pulses = 0; got_s = '0; got_c = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      s8 = (i == 3);
      a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        got_s = sum8;
        got_c = cout8;
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_sum", got_s, 8'h33);
    chk("ign_cout", got_c, 1'b0);

    // randomized, start held high
    run_rand(8, 1000);
    repeat (3) @(negedge clk);
    run_rand(3, 1000);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
